spi_master_v2: RTL and testbench

SPI_MASTER_V2 -- requirements
Module: spi_master_v2

---
 rtl/spi_master_v2.sv | 165 ++++++++++++++++
 tb/tb_spi_master_v2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_v2.sv
// SPI master with programmable mode, bit order, length, SCK divider and slave select.
// One transfer per accepted request; completion is reported with a single-cycle done pulse.
//
// state | meaning
// IDLE  | ready for a request, SCK parked at last CPOL, MOSI high
// LEAD  | slave selected, SCK idle, setup time before the first edge
// XFER  | 2*len SCK edges, one every div+1 clocks
// TRAIL | hold time after the last edge, slave still selected
// DONE  | slave released, rx_data_o updated, done_o high
module spi_master_v2 #(
   parameter  int DATA_W = 48,
   parameter  int NUM_SS = 4,
   parameter  int DIV_W  = 8,
   localparam int LEN_W  = $clog2(DATA_W + 1),
   // one extra bit so that an out-of-range slave index can actually be requested
   localparam int SS_W   = $clog2(NUM_SS) + 1
) (
   input  logic              spi_clk_i,
   input  logic              spi_rst_i,
   input  logic              start_i,
   output logic              ready_o,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsb_first_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [SS_W-1:0]   ss_sel_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              done_o,
   output logic              sck_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_SS-1:0] ss_n_o
);

   localparam int EC_W = LEN_W + 1;

   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

   state_t            state;
   logic              cpha_q;
   logic              lsb_q;
   logic [LEN_W-1:0]  len_q;
   logic [DIV_W-1:0]  div_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_sh;
   logic [DIV_W-1:0]  tmr;
   logic [EC_W-1:0]   edge_cnt;
   logic [LEN_W-1:0]  bit_idx;
   logic [LEN_W-1:0]  len_eff;
   logic [LEN_W-1:0]  cur_pos;
   logic [LEN_W-1:0]  nxt_pos;

   // transfer-order index -> data bit position
   function automatic logic [LEN_W-1:0] bit_pos(input logic lsb, input logic [LEN_W-1:0] len,
                                                input logic [LEN_W-1:0] idx);
      return lsb ? idx : (len - idx - LEN_W'(1));
   endfunction

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (sel == SS_W'(i)) v[i] = 1'b0;
      return v;
   endfunction

   always_comb begin
      len_eff = len_i;
      if (len_i == '0 || len_i > LEN_W'(DATA_W)) len_eff = LEN_W'(DATA_W);
      cur_pos = bit_pos(lsb_q, len_q, bit_idx);
      nxt_pos = bit_pos(lsb_q, len_q, bit_idx + LEN_W'(1));
   end

   always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
      if (!spi_rst_i) begin
         state     <= IDLE;
         ready_o   <= 1'b1;
         done_o    <= 1'b0;
         sck_o     <= 1'b0;
         mosi_o    <= 1'b1;
         ss_n_o    <= '1;
         rx_data_o <= '0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         len_q     <= '0;
         div_q     <= '0;
         tx_q      <= '0;
         rx_sh     <= '0;
         tmr       <= '0;
         edge_cnt  <= '0;
         bit_idx   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state   <= LEAD;
                  ready_o <= 1'b0;
                  cpha_q  <= cpha_i;
                  lsb_q   <= lsb_first_i;
                  len_q   <= len_eff;
                  div_q   <= div_i;
                  tx_q    <= tx_data_i;
                  tmr     <= div_i;
                  bit_idx <= '0;
                  rx_sh   <= '0;
                  sck_o   <= cpol_i;
                  ss_n_o  <= ss_decode(ss_sel_i);
                  mosi_o  <= tx_data_i[bit_pos(lsb_first_i, len_eff, '0)];
               end
            end
            LEAD: begin
               if (tmr == '0) begin
                  state    <= XFER;
                  tmr      <= div_q;
                  edge_cnt <= {len_q, 1'b0};
               end else begin
                  tmr <= tmr - DIV_W'(1);
               end
            end
            XFER: begin
               if (tmr == '0) begin
                  sck_o    <= ~sck_o;
                  tmr      <= div_q;
                  edge_cnt <= edge_cnt - EC_W'(1);
                  // an even remaining count means this is a leading (odd-numbered) edge
                  if (!edge_cnt[0]) begin
                     if (!cpha_q) rx_sh[cur_pos] <= miso_i;
                     else         mosi_o <= tx_q[cur_pos];
                  end else begin
                     if (cpha_q)                          rx_sh[cur_pos] <= miso_i;
                     else if (edge_cnt != EC_W'(1))       mosi_o <= tx_q[nxt_pos];
                     bit_idx <= bit_idx + LEN_W'(1);
                  end
                  if (edge_cnt == EC_W'(1)) state <= TRAIL;
               end else begin
                  tmr <= tmr - DIV_W'(1);
               end
            end
            TRAIL: begin
               if (tmr == '0) begin
                  state     <= DONE;
                  ss_n_o    <= '1;
                  mosi_o    <= 1'b1;
                  done_o    <= 1'b1;
                  rx_data_o <= rx_sh;
               end else begin
                  tmr <= tmr - DIV_W'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               ready_o <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_v2.sv
// Bench for spi_master_v2: randomized and directed transfers against a slave/timing model
// that predicts every cycle of ss_n/done/ready/sck and the bit streams in both directions.
module tb_spi_master_v2;

   localparam int DATA_W = 48;
   localparam int NUM_SS = 4;
   localparam int DIV_W  = 8;
   localparam int LEN_W  = $clog2(DATA_W + 1);
   localparam int SS_W   = $clog2(NUM_SS) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              ready;
   logic              cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic [DIV_W-1:0]  div = '0;
   logic [SS_W-1:0]   ss_sel = '0;
   logic [DATA_W-1:0] tx = '0;
   logic [DATA_W-1:0] rx;
   logic              done;
   logic              sck, mosi;
   logic              miso = 1'b0;
   logic [NUM_SS-1:0] ss_n;

   spi_master_v2 #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
      .spi_clk_i(clk), .spi_rst_i(rst_n), .start_i(start), .ready_o(ready),
      .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb), .len_i(len), .div_i(div),
      .ss_sel_i(ss_sel), .tx_data_i(tx), .rx_data_o(rx), .done_o(done),
      .sck_o(sck), .mosi_o(mosi), .miso_i(miso), .ss_n_o(ss_n));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic fail_to(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got=timeout expected=event", nm);
   endtask

   function automatic int bpos(input bit lb, input int ln, input int i);
      return lb ? i : ln - 1 - i;
   endfunction

   // slave-side controls set by the driver before each request
   logic [DATA_W-1:0] slave_bits = '0;
   bit                loop_mode  = 1'b0;

   // model state
   bit                active = 1'b0;
   int                n, E, k, done_n, m_len, m_div, cyc = 0;
   bit                m_cpol, m_cpha, m_lsb, m_loop, last_cpol = 1'b0;
   logic [NUM_SS-1:0] m_ss;
   logic [DATA_W-1:0] m_tx, m_sd, exp_rx, exp_mosi, got_mosi;
   logic              sck_prev;
   int                accepts = 0, xfers = 0, acc_prev = 0, acc_last = 0;
   int                res_lat;
   logic [DATA_W-1:0] res_rx, res_mosi;

   // input samples from the previous falling edge = what the DUT saw at the rising edge
   bit                s_start = 0, s_ready = 0, s_rst = 0, s_cpol, s_cpha, s_lsb;
   int                s_len, s_div, s_ss;
   logic [DATA_W-1:0] s_tx;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         active    = 1'b0;
         last_cpol = 1'b0;
      end else begin
         if (s_rst && s_start && s_ready) begin
            active   = 1'b1;
            n        = 0;
            accepts++;
            acc_prev = acc_last;
            acc_last = cyc;
            m_cpol   = s_cpol;
            m_cpha   = s_cpha;
            m_lsb    = s_lsb;
            m_len    = (s_len == 0 || s_len > DATA_W) ? DATA_W : s_len;
            m_div    = s_div;
            m_tx     = s_tx;
            m_sd     = slave_bits;
            m_loop   = loop_mode;
            m_ss     = '1;
            if (s_ss < NUM_SS) m_ss[s_ss] = 1'b0;
            E        = (m_div + 1) * (2 * m_len + 2);
            k        = 0;
            done_n   = -1;
            got_mosi = '0;
            exp_rx   = '0;
            exp_mosi = '0;
            for (int i = 0; i < m_len; i++) begin
               exp_mosi[i] = m_tx[bpos(m_lsb, m_len, i)];
               exp_rx[bpos(m_lsb, m_len, i)] = m_loop ? m_tx[bpos(m_lsb, m_len, i)] : m_sd[i];
            end
            last_cpol = m_cpol;
            sck_prev  = m_cpol;
         end else if (active) begin
            n++;
         end

         if (active) begin
            chk("ss_n", ss_n, (n < E) ? m_ss : {NUM_SS{1'b1}});
            chk("done", done, n == E);
            chk("ready", ready, n > E);
            if (done && done_n < 0) done_n = n;
            if (n == 0) chk("sck_lead", sck, m_cpol);
            if (n == 0 && !m_cpha) chk("mosi_lead", mosi, m_tx[bpos(m_lsb, m_len, 0)]);
            if (sck !== sck_prev) begin
               k++;
               sck_prev = sck;
               chk("edge_time", n, (k + 1) * (m_div + 1));
               if (!m_cpha && (k % 2) == 1 && (k - 1) / 2 < DATA_W) got_mosi[(k - 1) / 2] = mosi;
               if (m_cpha && (k % 2) == 0 && k / 2 - 1 < DATA_W)    got_mosi[k / 2 - 1] = mosi;
               if (!m_loop) begin
                  if (!m_cpha && (k % 2) == 0 && k / 2 < m_len) miso = m_sd[k / 2];
                  if (m_cpha && (k % 2) == 1 && (k - 1) / 2 < m_len) miso = m_sd[(k - 1) / 2];
               end
            end
            if (n == 0 && !m_cpha && !m_loop) miso = m_sd[0];
            if (m_loop) miso = mosi;
            if (n == E + 1) begin
               chk("edge_count", k, 2 * m_len);
               chk("mosi_seq", got_mosi, exp_mosi);
               chk("rx_data", rx, exp_rx);
               chk("latency", done_n + 1, E + 1);
               chk("sck_idle", sck, m_cpol);
               res_lat  = done_n + 1;
               res_rx   = rx;
               res_mosi = got_mosi;
               xfers++;
               active = 1'b0;
            end
         end else begin
            chk("idle_done", done, 1'b0);
            chk("idle_ready", ready, 1'b1);
            chk("idle_mosi", mosi, 1'b1);
            chk("idle_sck", sck, last_cpol);
         end
      end
      s_start = start;  s_ready = ready;  s_rst = rst_n;
      s_cpol  = cpol;   s_cpha  = cpha;   s_lsb = lsb;
      s_len   = int'(len);  s_div = int'(div);  s_ss = int'(ss_sel);  s_tx = tx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_xfers(input int target, input string nm);
      int t = 0;
      while (xfers < target && t < 3000) begin tick(); t++; end
      if (xfers < target) fail_to(nm);
   endtask

   task automatic run(input bit cp, input bit ph, input bit lb, input int ln, input int dv,
                      input int sl, input logic [DATA_W-1:0] t, input logic [DATA_W-1:0] sd,
                      input bit lp, input bit scr);
      int w = 0;
      int x0;
      logic [63:0] r;
      while (!ready && w < 3000) begin tick(); w++; end
      if (!ready) fail_to("wait_ready");
      x0 = xfers;
      cpol = cp; cpha = ph; lsb = lb; len = LEN_W'(ln); div = DIV_W'(dv);
      ss_sel = SS_W'(sl); tx = t; slave_bits = sd; loop_mode = lp; start = 1'b1;
      tick();
      start = 1'b0;
      if (scr) begin
         r = {$urandom(), $urandom()};
         cpol = 1'($urandom()); cpha = 1'($urandom()); lsb = 1'($urandom());
         len = LEN_W'($urandom()); div = DIV_W'($urandom_range(0, 3));
         ss_sel = SS_W'($urandom()); tx = r[DATA_W-1:0];
      end
      wait_xfers(x0 + 1, "xfer_done");
   endtask

   initial begin
      #1_000_000;
      fail_to("watchdog");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [63:0] r, rs;
      int a0, x0, t, xb;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_sck", sck, 1'b0);
      chk("rst_mosi", mosi, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", ready, 1'b1);
      chk("rst_rx", rx, 48'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // mode 0, MSB-first, loopback
      run(0, 0, 0, 8, 1, 0, 48'hA5, '0, 1'b1, 1'b0);
      chk("pin_a5_mosi", res_mosi, 48'hA5);
      chk("pin_a5_rx", res_rx, 48'hA5);
      chk("pin_a5_lat", res_lat, 37);

      // four modes, full length, random slave data
      for (int m = 0; m < 4; m++) begin
         r = {$urandom(), $urandom()};
         run(m[1], m[0], 0, 48, $urandom_range(0, 2), 1, 48'h123456789ABC, r[DATA_W-1:0], 1'b0, 1'b1);
      end

      // LSB-first, MISO tied high
      run(0, 0, 1, 5, 0, 3, 48'h13, '1, 1'b0, 1'b0);
      chk("pin_lsb5_mosi", res_mosi, 48'h13);
      chk("pin_lsb5_rx", res_rx, 48'h1F);
      chk("pin_lsb5_lat", res_lat, 13);

      // valid and out-of-range slave index, same timing
      run(0, 0, 0, 8, 1, 2, 48'h3C, 48'h5A, 1'b0, 1'b0);
      chk("pin_ss2_lat", res_lat, 37);
      run(0, 0, 0, 8, 1, 5, 48'h3C, 48'h5A, 1'b0, 1'b0);
      chk("pin_ss5_lat", res_lat, 37);

      // length 0 and oversize both mean full width
      r = {$urandom(), $urandom()};
      run(1, 0, 1, 0, 0, 0, r[DATA_W-1:0], r[DATA_W-1:0] ^ 48'hFFFF, 1'b0, 1'b0);
      chk("pin_len0_lat", res_lat, 99);
      run(0, 1, 0, 55, 0, 0, r[DATA_W-1:0], ~r[DATA_W-1:0], 1'b0, 1'b0);

      // mid-transfer start pulse ignored, held start gives back-to-back transfers
      a0 = accepts;
      x0 = xfers;
      cpol = 0; cpha = 1; lsb = 0; len = 8; div = 1; ss_sel = 1; tx = 48'hC3;
      slave_bits = 48'h96; loop_mode = 0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1;
      t = 0;
      while (accepts < a0 + 2 && t < 300) begin tick(); t++; end
      start = 1'b0;
      if (accepts < a0 + 2) fail_to("b2b_accept");
      chk("b2b_accepts", accepts - a0, 2);
      chk("b2b_gap", acc_last - acc_prev, 38);
      wait_xfers(x0 + 2, "b2b_done");

      // random transfers with inputs scrambled during the transfer
      for (int it = 0; it < 16; it++) begin
         r  = {$urandom(), $urandom()};
         rs = {$urandom(), $urandom()};
         run(1'($urandom()), 1'($urandom()), 1'($urandom()), $urandom_range(0, 63),
             $urandom_range(0, 3), $urandom_range(0, 7), r[DATA_W-1:0], rs[DATA_W-1:0],
             1'($urandom_range(0, 3) == 0), 1'b1);
      end

      // reset during XFER aborts without done and the next transfer is normal
      xb = xfers;
      cpol = 1; cpha = 0; lsb = 0; len = 48; div = 2; ss_sel = 0; tx = 48'hFEDCBA987654;
      slave_bits = 48'h0F0F0F0F0F0F; loop_mode = 0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_ss_n", ss_n, 4'hF);
      chk("abort_sck", sck, 1'b0);
      chk("abort_mosi", mosi, 1'b1);
      chk("abort_done", done, 1'b0);
      chk("abort_ready", ready, 1'b1);
      chk("abort_rx", rx, 48'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("abort_no_done", xfers, xb);
      run(0, 1, 1, 12, 1, 3, 48'hABC, 48'h5A5, 1'b0, 1'b0);
      chk("post_abort_lat", res_lat, 53);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
